// File: rtl/syncfifo_ctrl.sv
// Synchronous FIFO controller: level-tracked occupancy, programmable
// almost-full/almost-empty thresholds, synchronous flush, sticky
// overflow/underflow flags, and standard or first-word-fall-through reads.
module syncfifo_ctrl #(
  parameter int DW   = 24,
  parameter int AW   = 7,
  parameter int FWFT = 0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          clr_err_i,
  input  logic          wr_i,
  input  logic [DW-1:0] din_i,
  input  logic          rd_i,
  output logic [DW-1:0] dout_o,
  input  logic [AW:0]   af_thresh_i,
  input  logic [AW:0]   ae_thresh_i,
  output logic          full_o,
  output logic          empty_o,
  output logic          almost_full_o,
  output logic          almost_empty_o,
  output logic [AW:0]   level_o,
  output logic          overflow_o,
  output logic          underflow_o
);

  localparam int              DEPTH   = 2 ** AW;
  localparam logic [AW:0]     DEPTH_L = (AW + 1)'(DEPTH);
  localparam logic [AW:0]     LVL_ONE = (AW + 1)'(1);
  localparam logic [AW:0]     LVL_ZERO = (AW + 1)'(0);
  localparam logic [AW-1:0]   PTR_ONE = AW'(1);
  localparam logic [AW-1:0]   PTR_ZERO = AW'(0);

  logic [DW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic          active_s;
  logic          rd_acc_s;
  logic          wr_acc_s;

  // Accept decisions; flush and reset suppress all traffic in their cycle.
  always_comb begin
    active_s = ~rst_i & ~flush_i;
    rd_acc_s = active_s & rd_i & ~empty_q;
    // A write into a full FIFO only goes through when a read frees a slot.
    wr_acc_s = active_s & wr_i & (~full_q | rd_acc_s);
  end

  // Next pointers, occupancy and full/empty flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
      level_d  = LVL_ZERO;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_acc_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
    full_d  = (level_d == DEPTH_L);
    empty_d = (level_d == LVL_ZERO);
  end

  // Sticky error flags; a new error in the same cycle beats a clear.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (active_s & wr_i & ~wr_acc_s) begin
      ovf_d = 1'b1;
    end else if (clr_err_i) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (active_s & rd_i & ~rd_acc_s) begin
      udf_d = 1'b1;
    end else if (clr_err_i) begin
      udf_d = 1'b0;
    end else begin
      udf_d = udf_q;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      level_q  <= LVL_ZERO;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (wr_acc_s) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented directly; meaningless while empty.
      assign dout_o = mem_q[rd_ptr_q];
    end else begin : g_std
      logic [DW-1:0] dout_q, dout_d;

      // Capture the head word only on an accepted read, hold otherwise.
      always_comb begin
        dout_d = dout_q;
        if (rd_acc_s) begin
          dout_d = mem_q[rd_ptr_q];
        end else begin
          dout_d = dout_q;
        end
      end

      // Registered read data.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          dout_q <= {DW{1'b0}};
        end else begin
          dout_q <= dout_d;
        end
      end

      assign dout_o = dout_q;
    end
  endgenerate

  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign level_o        = level_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;
  assign almost_full_o  = (level_q >= af_thresh_i);
  assign almost_empty_o = (level_q <= ae_thresh_i);

endmodule

// File: tb/tb_syncfifo_ctrl.sv
// Scoreboard bench for syncfifo_ctrl: a standard-read and an FWFT instance
// share one stimulus stream and are checked against a queue-based model.
module tb_syncfifo_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0, flush_i = 1'b0, clr_err_i = 1'b0;
  logic          wr_i = 1'b0, rd_i = 1'b0;
  logic [DW-1:0] din_i = 8'h00;
  logic [AW:0]   af_thresh = 3'd3, ae_thresh = 3'd1;

  logic [DW-1:0] s_dout, f_dout;
  logic          s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic          f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [AW:0]   s_level, f_level;

  always #5 clk = ~clk;

  syncfifo_ctrl #(.DW(DW), .AW(AW), .FWFT(0)) u_std (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .clr_err_i(clr_err_i),
    .wr_i(wr_i), .din_i(din_i), .rd_i(rd_i), .dout_o(s_dout),
    .af_thresh_i(af_thresh), .ae_thresh_i(ae_thresh),
    .full_o(s_full), .empty_o(s_empty), .almost_full_o(s_af),
    .almost_empty_o(s_ae), .level_o(s_level),
    .overflow_o(s_ovf), .underflow_o(s_udf)
  );

  syncfifo_ctrl #(.DW(DW), .AW(AW), .FWFT(1)) u_fwft (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .clr_err_i(clr_err_i),
    .wr_i(wr_i), .din_i(din_i), .rd_i(rd_i), .dout_o(f_dout),
    .af_thresh_i(af_thresh), .ae_thresh_i(ae_thresh),
    .full_o(f_full), .empty_o(f_empty), .almost_full_o(f_af),
    .almost_empty_o(f_ae), .level_o(f_level),
    .overflow_o(f_ovf), .underflow_o(f_udf)
  );

  typedef struct {
    int          cyc;
    int          lvl;
    bit          ovf;
    bit          udf;
    logic [7:0]  dstd;
    bit          hv;
    logic [7:0]  head;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mq[$];
  bit          m_ovf = 1'b0, m_udf = 1'b0;
  logic [7:0]  m_dstd = 8'h00;
  int          cycle_cnt = 0;
  int          n_cmp = 0, n_bad = 0;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cycle_cnt, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, advance the model, queue the expected state.
  task automatic cyc(input bit rst, input bit flush, input bit clr,
                     input bit wr, input bit rd, input logic [7:0] din);
    exp_t e;
    bit   racc, wacc;
    rst_i = rst; flush_i = flush; clr_err_i = clr;
    wr_i = wr; rd_i = rd; din_i = din;
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_dstd = 8'h00;
    end else if (flush) begin
      mq.delete();
      if (clr) begin m_ovf = 1'b0; m_udf = 1'b0; end
    end else begin
      racc = rd && (mq.size() > 0);
      wacc = wr && ((mq.size() < DEPTH) || racc);
      if (racc) m_dstd = mq.pop_front();
      if (wacc) mq.push_back(din);
      if (wr && !wacc) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
      if (rd && !racc) m_udf = 1'b1; else if (clr) m_udf = 1'b0;
    end
    e.cyc  = cycle_cnt + 1;
    e.lvl  = mq.size();
    e.ovf  = m_ovf;
    e.udf  = m_udf;
    e.dstd = m_dstd;
    e.hv   = (mq.size() > 0);
    e.head = (mq.size() > 0) ? mq[0] : 8'h00;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT outputs against the expectation due this cycle.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cycle_cnt) begin
        e = exp_q.pop_front();
        check("due_cycle", e.cyc, cycle_cnt);
        check("level", s_level, e.lvl);
        check("full", s_full, e.lvl == DEPTH);
        check("empty", s_empty, e.lvl == 0);
        check("almost_full", s_af, e.lvl >= int'(af_thresh));
        check("almost_empty", s_ae, e.lvl <= int'(ae_thresh));
        check("overflow", s_ovf, e.ovf);
        check("underflow", s_udf, e.udf);
        check("dout_std", s_dout, e.dstd);
        check("fwft_level", f_level, e.lvl);
        check("fwft_empty", f_empty, e.lvl == 0);
        check("fwft_full", f_full, e.lvl == DEPTH);
        check("fwft_af", f_af, e.lvl >= int'(af_thresh));
        check("fwft_ae", f_ae, e.lvl <= int'(ae_thresh));
        check("fwft_overflow", f_ovf, e.ovf);
        check("fwft_underflow", f_udf, e.udf);
        if (e.hv) check("fwft_dout", f_dout, e.head);
      end
    end
  end

  initial begin : drv
    repeat (2) @(posedge clk);
    #1;
    cyc(1, 0, 0, 0, 0, 8'h00);
    // Fill to full, then overflow, then read+write at full.
    cyc(0, 0, 0, 1, 0, 8'h11);
    cyc(0, 0, 0, 1, 0, 8'h22);
    cyc(0, 0, 0, 1, 0, 8'h33);
    cyc(0, 0, 0, 1, 0, 8'h44);
    cyc(0, 0, 0, 1, 0, 8'h55);
    cyc(0, 0, 0, 1, 1, 8'h66);
    cyc(0, 0, 1, 0, 0, 8'h00);
    repeat (4) cyc(0, 0, 0, 0, 1, 8'h00);
    // Underflow with a simultaneous write into the empty FIFO.
    cyc(0, 0, 0, 1, 1, 8'h5A);
    cyc(0, 0, 0, 0, 1, 8'h00);
    cyc(0, 0, 1, 0, 0, 8'h00);
    // FWFT head presentation.
    cyc(0, 0, 0, 1, 0, 8'hA1);
    cyc(0, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 1, 0, 8'hB2);
    cyc(0, 0, 0, 0, 1, 8'h00);
    cyc(0, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 1, 8'h00);
    // Level 3 with wrapped pointers, then flush with a write pending.
    cyc(0, 0, 0, 1, 0, 8'hC1);
    cyc(0, 0, 0, 1, 0, 8'hC2);
    cyc(0, 0, 0, 1, 0, 8'hC3);
    cyc(0, 1, 0, 1, 1, 8'hEE);
    cyc(0, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 1, 8'h00);
    // Reset mid-stream at level 2.
    cyc(0, 0, 0, 1, 0, 8'hD1);
    cyc(0, 0, 0, 1, 0, 8'hD2);
    cyc(1, 0, 0, 1, 1, 8'hD3);
    cyc(0, 0, 0, 0, 0, 8'h00);
    // Threshold extremes: af=0 always set, ae=DEPTH always set.
    af_thresh = 3'd0; ae_thresh = 3'd4;
    repeat (5) cyc(0, 0, 0, 1, 0, 8'h70);
    ae_thresh = 3'd7;
    repeat (5) cyc(0, 0, 0, 0, 1, 8'h00);
    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if (i % 25 == 0) begin
        af_thresh = 3'($urandom_range(0, 7));
        ae_thresh = 3'($urandom_range(0, 7));
      end
      cyc($urandom_range(0, 149) == 0, $urandom_range(0, 39) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 99) < 60,
          $urandom_range(0, 99) < 50, 8'($urandom));
    end
    cyc(0, 0, 0, 0, 0, 8'h00);
    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
